// File: rtl/context_switch_ctrl.sv
// Context-switch sequencer: on quantum expiry or process exit it saves the running
// context to its memory slot, picks the next live PID round-robin, and restores it.
module context_switch_ctrl #(
    parameter int          NUM_PROCS = 8,
    parameter int          PID_W     = 3,
    parameter logic [31:0] CTX_BASE  = 32'h0000_0400
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 OutOfQuantum,
    input  logic                 Finalize,
    input  logic [NUM_PROCS-1:0] ProcValid,
    input  logic [31:0]          CurPC,
    output logic [4:0]           RegReadAddr,
    input  logic [31:0]          RegReadData,
    output logic                 RegWrite,
    output logic [4:0]           RegWriteAddr,
    output logic [31:0]          RegWriteData,
    output logic [31:0]          MemAddr,
    output logic                 MemWrite,
    output logic [31:0]          MemWriteData,
    output logic                 MemRead,
    input  logic [31:0]          MemReadData,
    output logic                 Stall,
    output logic                 PREEMP_ON,
    output logic                 PREEMP_OFF,
    output logic                 LoadPC,
    output logic [31:0]          NewPC,
    output logic [PID_W-1:0]     CurPID,
    output logic                 Halted
);

    typedef enum logic [2:0] {IDLE, SAVE, PICK, RESTORE, RESUME} state_t;

    state_t               state, state_nxt;
    logic [5:0]           idx;
    logic [5:0]           idx_m1;
    logic [31:0]          saved_pc;
    logic [PID_W-1:0]     new_pid;
    logic                 exclude_cur;
    logic [NUM_PROCS-1:0] prev_valid;
    logic                 restart, trig_fin, trig_oq;
    logic                 pick_found;
    logic [PID_W-1:0]     pick_pid;
    logic [PID_W-1:0]     cand;

    function automatic logic [31:0] slot_addr(input logic [PID_W-1:0] pid, input logic [4:0] word);
        return CTX_BASE + 32'({pid, word});
    endfunction

    assign idx_m1   = idx - 6'd1;
    assign restart  = Halted && (|(ProcValid & ~prev_valid));
    assign trig_fin = !Halted && Finalize;
    assign trig_oq  = !Halted && OutOfQuantum && !Finalize;

    // Round-robin scan starting after CurPID; CurPID itself is the last candidate
    always_comb begin
        pick_found = 1'b0;
        pick_pid   = CurPID;
        cand       = '0;
        for (int i = 1; i <= NUM_PROCS; i++) begin
            cand = CurPID + PID_W'(i);
            if (!pick_found && ProcValid[cand] && !(exclude_cur && i == NUM_PROCS)) begin
                pick_found = 1'b1;
                pick_pid   = cand;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        Stall        = 1'b0;
        PREEMP_ON    = 1'b0;
        PREEMP_OFF   = 1'b0;
        LoadPC       = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        MemAddr      = 32'd0;
        MemWriteData = 32'd0;
        RegReadAddr  = 5'd0;
        RegWrite     = 1'b0;
        RegWriteAddr = 5'd0;
        RegWriteData = 32'd0;
        case (state)
            IDLE: begin
                Stall = Halted;
                if (restart) begin
                    Stall     = 1'b1;
                    state_nxt = PICK;
                end else if (trig_fin) begin
                    Stall      = 1'b1;
                    PREEMP_OFF = 1'b1;
                    state_nxt  = PICK;
                end else if (trig_oq) begin
                    Stall      = 1'b1;
                    PREEMP_OFF = 1'b1;
                    state_nxt  = SAVE;
                end
            end
            SAVE: begin
                Stall        = 1'b1;
                MemWrite     = 1'b1;
                MemAddr      = slot_addr(CurPID, idx[4:0]);
                RegReadAddr  = idx[4:0];
                MemWriteData = (idx == 6'd0) ? saved_pc : RegReadData;
                if (idx == 6'd31) state_nxt = PICK;
            end
            PICK: begin
                Stall     = 1'b1;
                state_nxt = pick_found ? RESTORE : IDLE;
            end
            RESTORE: begin
                // Memory returns word j-1 in step j; word 0 is the PC, handled in the register block
                Stall = 1'b1;
                if (idx <= 6'd31) begin
                    MemRead = 1'b1;
                    MemAddr = slot_addr(new_pid, idx[4:0]);
                end
                if (idx >= 6'd2) begin
                    RegWrite     = 1'b1;
                    RegWriteAddr = idx_m1[4:0];
                    RegWriteData = MemReadData;
                end
                if (idx == 6'd32) state_nxt = RESUME;
            end
            RESUME: begin
                Stall     = 1'b1;
                LoadPC    = 1'b1;
                PREEMP_ON = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            idx         <= 6'd0;
            CurPID      <= '0;
            NewPC       <= 32'd0;
            Halted      <= 1'b0;
            exclude_cur <= 1'b0;
            prev_valid  <= '0;
        end else begin
            state      <= state_nxt;
            prev_valid <= ProcValid;
            case (state)
                IDLE: begin
                    idx         <= 6'd0;
                    exclude_cur <= trig_fin && !restart;
                end
                SAVE:    idx <= (idx == 6'd31) ? 6'd0 : idx + 6'd1;
                PICK: begin
                    idx    <= 6'd0;
                    Halted <= !pick_found;
                end
                RESTORE: begin
                    idx <= idx + 6'd1;
                    if (idx == 6'd1) NewPC <= MemReadData;
                end
                RESUME:  CurPID <= new_pid;
                default: idx <= 6'd0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE) saved_pc <= CurPC;
        if (state == PICK && pick_found) new_pid <= pick_pid;
    end

endmodule

// File: tb/tb_context_switch_ctrl.sv
// Bench for context_switch_ctrl: register file and data memory models plus a
// slot-level reference model of what each switch should save, pick and restore.
module tb_context_switch_ctrl;

    localparam int NP = 8;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        OutOfQuantum = 1'b0;
    logic        Finalize = 1'b0;
    logic [7:0]  ProcValid = 8'd0;
    logic [31:0] CurPC = 32'd0;
    logic [4:0]  RegReadAddr;
    logic [31:0] RegReadData;
    logic        RegWrite;
    logic [4:0]  RegWriteAddr;
    logic [31:0] RegWriteData;
    logic [31:0] MemAddr;
    logic        MemWrite;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic [31:0] MemReadData;
    logic        Stall, PREEMP_ON, PREEMP_OFF, LoadPC;
    logic [31:0] NewPC;
    logic [2:0]  CurPID;
    logic        Halted;

    bit [31:0] rf  [32];
    bit [31:0] mem [2048];

    logic        tb_rf_we = 1'b0;
    logic [4:0]  tb_rf_a = 5'd0;
    logic [31:0] tb_rf_d = 32'd0;
    logic        tb_mem_we = 1'b0;
    logic [10:0] tb_mem_a = 11'd0;
    logic [31:0] tb_mem_d = 32'd0;

    bit [31:0] exp_mem [NP][32];
    bit [31:0] exp_rf  [32];
    bit [31:0] exp_newpc;
    int        model_pid;
    int        checks = 0;
    int        failures = 0;

    context_switch_ctrl dut (
        .CLK(CLK), .Reset(Reset), .OutOfQuantum(OutOfQuantum), .Finalize(Finalize),
        .ProcValid(ProcValid), .CurPC(CurPC),
        .RegReadAddr(RegReadAddr), .RegReadData(RegReadData),
        .RegWrite(RegWrite), .RegWriteAddr(RegWriteAddr), .RegWriteData(RegWriteData),
        .MemAddr(MemAddr), .MemWrite(MemWrite), .MemWriteData(MemWriteData),
        .MemRead(MemRead), .MemReadData(MemReadData),
        .Stall(Stall), .PREEMP_ON(PREEMP_ON), .PREEMP_OFF(PREEMP_OFF),
        .LoadPC(LoadPC), .NewPC(NewPC), .CurPID(CurPID), .Halted(Halted)
    );

    always #5 CLK = ~CLK;

    assign RegReadData = rf[RegReadAddr];

    always @(posedge CLK) begin
        if (tb_rf_we) rf[tb_rf_a] <= tb_rf_d;
        else if (RegWrite) rf[RegWriteAddr] <= RegWriteData;
    end

    always @(posedge CLK) begin
        if (tb_mem_we) mem[tb_mem_a] <= tb_mem_d;
        else if (MemWrite) mem[MemAddr[10:0]] <= MemWriteData;
        if (MemRead) MemReadData <= mem[MemAddr[10:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic poke_rf(input int a, input logic [31:0] d);
        tb_rf_a = 5'(a);
        tb_rf_d = d;
        tb_rf_we = 1'b1;
        @(posedge CLK);
        #1 tb_rf_we = 1'b0;
        exp_rf[a] = d;
    endtask

    task automatic poke_slot(input int pid, input int w, input logic [31:0] d);
        tb_mem_a = 11'(1024 + pid * 32 + w);
        tb_mem_d = d;
        tb_mem_we = 1'b1;
        @(posedge CLK);
        #1 tb_mem_we = 1'b0;
        exp_mem[pid][w] = d;
    endtask

    // mode 0: quantum expiry, 1: Finalize together with OutOfQuantum, 2: ProcValid rises while halted
    task automatic run_switch(input int mode, input logic [7:0] pv, input logic [31:0] pc);
        int from, to, resume_k, nw, nr, addr_bad, stall_bad, lp_k, lp_cnt, on_k, r0w, off_extra, bad;
        bit save, excl, found;
        from = model_pid;
        save = (mode == 0);
        excl = (mode == 1);
        resume_k = save ? 67 : 35;
        to = from;
        found = 1'b0;
        for (int i = 1; i <= NP; i++) begin
            int c;
            c = (from + i) % NP;
            if (!found && pv[c[2:0]] && !(excl && i == NP)) begin
                found = 1'b1;
                to = c;
            end
        end
        if (save) begin
            exp_mem[from][0] = pc;
            for (int k = 1; k < 32; k++) exp_mem[from][k] = exp_rf[k];
        end
        for (int k = 1; k < 32; k++) exp_rf[k] = exp_mem[to][k];
        exp_newpc = exp_mem[to][0];

        nw = 0; nr = 0; addr_bad = 0; stall_bad = 0; lp_k = -1; lp_cnt = 0;
        on_k = -1; r0w = 0; off_extra = 0;
        @(negedge CLK);
        ProcValid = pv;
        CurPC = pc;
        if (mode == 0) OutOfQuantum = 1'b1;
        if (mode == 1) begin
            Finalize = 1'b1;
            OutOfQuantum = 1'b1;
        end
        #1;
        check("stall_at_trigger", 32'(Stall), 32'd1);
        check("preemp_off_at_trigger", 32'(PREEMP_OFF), (mode != 2) ? 32'd1 : 32'd0);
        for (int k = 1; k <= resume_k + 1; k++) begin
            @(negedge CLK);
            OutOfQuantum = 1'b0;
            Finalize = 1'b0;
            #1;
            if (Stall !== (k <= resume_k)) stall_bad++;
            if (MemWrite === 1'b1) begin
                nw++;
                if (MemAddr !== 32'(1024 + from * 32 + k - 1)) addr_bad++;
            end
            if (MemRead === 1'b1) nr++;
            if (LoadPC === 1'b1) begin
                lp_cnt++;
                lp_k = k;
            end
            if (PREEMP_ON === 1'b1) on_k = k;
            if (RegWrite === 1'b1 && RegWriteAddr === 5'd0) r0w++;
            if (PREEMP_OFF !== 1'b0) off_extra++;
        end
        check("stall_window_errors", 32'(stall_bad), 32'd0);
        check("mem_write_count", 32'(nw), save ? 32'd32 : 32'd0);
        check("save_addr_errors", 32'(addr_bad), 32'd0);
        check("mem_read_count", 32'(nr), 32'd32);
        check("loadpc_cycle", 32'(lp_k), 32'(resume_k));
        check("loadpc_pulses", 32'(lp_cnt), 32'd1);
        check("preemp_on_cycle", 32'(on_k), 32'(resume_k));
        check("r0_writes", 32'(r0w), 32'd0);
        check("extra_preemp_off", 32'(off_extra), 32'd0);
        check("cur_pid", 32'(CurPID), 32'(to));
        check("new_pc", NewPC, exp_newpc);
        check("halted_after", 32'(Halted), 32'd0);
        if (save) begin
            bad = 0;
            for (int w = 0; w < 32; w++)
                if (mem[1024 + from * 32 + w] !== exp_mem[from][w]) bad++;
            check("saved_slot_words_wrong", 32'(bad), 32'd0);
        end
        bad = 0;
        for (int r = 0; r < 32; r++)
            if (rf[r] !== exp_rf[r]) bad++;
        check("restored_regs_wrong", 32'(bad), 32'd0);
        model_pid = to;
    endtask

    initial begin
        model_pid = 0;
        exp_newpc = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        for (int r = 0; r < 32; r++)
            poke_rf(r, (r == 0) ? 32'hA5A5_0000 : (r == 5) ? 32'hDEAD_BEEF : $urandom);
        for (int w = 0; w < 32; w++) begin
            poke_slot(1, w, (w == 0) ? 32'h2000 : (w == 7) ? 32'd7 : $urandom);
            poke_slot(2, w, $urandom);
            poke_slot(7, w, $urandom);
        end
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        check("reset_controls",
              32'({Stall, MemWrite, MemRead, RegWrite, LoadPC, PREEMP_ON, PREEMP_OFF, Halted}), 32'd0);
        check("reset_cur_pid", 32'(CurPID), 32'd0);
        check("reset_new_pc", NewPC, 32'd0);
        check("reset_mem_addr", MemAddr, 32'd0);

        // Quantum switch 0 -> 1 with the directed register and slot values
        run_switch(0, 8'b0000_0011, 32'h100);
        check("slot0_pc", mem[1024], 32'h100);
        check("slot0_r5", mem[1029], 32'hDEAD_BEEF);
        check("r7_restored", rf[7], 32'd7);
        check("new_pc_slot1", NewPC, 32'h2000);
        check("r0_untouched", rf[0], 32'hA5A5_0000);

        run_switch(0, 8'b0000_0001, $urandom);
        // Finalize wins over a simultaneous quantum expiry; PID 0 excluded -> 7
        run_switch(1, 8'b1000_0001, $urandom);
        // PID wraps 7 -> 0
        run_switch(0, 8'b1000_0001, $urandom);

        // Only the running process is live: it restores its own freshly saved context
        for (int n = 0; n < 8; n++) poke_rf(1 + int'($urandom_range(30)), $urandom);
        run_switch(0, 8'b0000_0001, $urandom);

        // Finalize with nothing live halts and keeps the core stalled
        @(negedge CLK);
        ProcValid = 8'd0;
        Finalize = 1'b1;
        #1;
        check("halt_stall_at_trigger", 32'(Stall), 32'd1);
        check("halt_preemp_off", 32'(PREEMP_OFF), 32'd1);
        @(negedge CLK);
        Finalize = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("halted_set", 32'(Halted), 32'd1);
        check("halted_stall", 32'(Stall), 32'd1);
        check("halted_no_loadpc", 32'(LoadPC), 32'd0);
        check("halted_no_read", 32'(MemRead), 32'd0);
        check("halted_pid_kept", 32'(CurPID), 32'(model_pid));
        @(negedge CLK);
        OutOfQuantum = 1'b1;
        #1;
        check("halted_ignores_quantum", 32'(PREEMP_OFF), 32'd0);
        @(negedge CLK);
        OutOfQuantum = 1'b0;
        #1;
        check("halted_no_save", 32'(MemWrite), 32'd0);
        check("halted_still", 32'(Halted), 32'd1);

        // A process becoming live restarts scheduling
        run_switch(2, 8'b0000_0100, 32'd0);

        // Reset in the middle of a save; the slot is rewritten with its own contents
        @(negedge CLK);
        ProcValid = 8'b0000_0101;
        CurPC = exp_newpc;
        OutOfQuantum = 1'b1;
        #1;
        check("abort_stall_at_trigger", 32'(Stall), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            OutOfQuantum = 1'b0;
            if (k == 20) Reset = 1'b1;
        end
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        check("abort_controls",
              32'({Stall, MemWrite, MemRead, RegWrite, LoadPC, PREEMP_ON, PREEMP_OFF, Halted}), 32'd0);
        check("abort_cur_pid", 32'(CurPID), 32'd0);
        check("abort_new_pc", NewPC, 32'd0);
        check("abort_mem_addr", MemAddr, 32'd0);
        model_pid = 0;
        exp_newpc = 32'd0;
        run_switch(0, 8'b0000_0101, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/context_switch_ctrl.md
# context_switch_ctrl

Responder to the preemption timer's quantum-expiry request. On `OutOfQuantum` or `Finalize` it stalls the core and freezes the timer. It saves the running process's PC and r1..r31 into its context slot in data memory, picks the next live process round-robin, and restores that process's context. It then reloads the PC and re-arms the timer through `PREEMP_ON`. It sits between the timer, the register file, the data-memory port and the PC logic.

## Interface
- `NUM_PROCS`, 8: process table entries.
- `PID_W`, 3: log2(NUM_PROCS).
- `CTX_BASE`, 32'h0000_0400: word address of the slot for PID 0. Slot size is fixed at 32 words.
- `CLK` in 1: single clock; all state updates on posedge.
- `Reset` in 1: synchronous, active-high.
- `OutOfQuantum` in 1: quantum expired (from timer).
- `Finalize` in 1: current process exited; its context is not saved.
- `ProcValid` in NUM_PROCS: bit p = process p is live.
- `CurPC` in 32: PC of the running process.
- `RegReadAddr` out 5, `RegReadData` in 32: register file read; combinational, same-cycle data.
- `RegWrite` out 1, `RegWriteAddr` out 5, `RegWriteData` out 32: register file write port.
- `MemAddr` out 32, `MemWrite` out 1, `MemWriteData` out 32: data memory port. Word-addressed.
- `MemRead` out 1, `MemReadData` in 32: data memory read; data is valid the cycle after the address.
- `Stall` out 1: freeze pipeline.
- `PREEMP_ON`, `PREEMP_OFF` out 1: one-cycle pulses to the timer.
- `LoadPC` out 1, `NewPC` out 32: PC reload, one-cycle pulse.
- `CurPID` out PID_W: running process ID.
- `Halted` out 1: no live process.

## Operation
- Slot address is `CTX_BASE + {pid, idx[4:0]}`.
  - Word 0 holds the PC.
  - Words 1..31 hold r1..r31.
  - r0 is never saved or written.
- States: IDLE, SAVE, PICK, RESTORE, RESUME.
- IDLE:
  - If `Finalize`=1, go to PICK. Finalize wins over a simultaneous `OutOfQuantum`.
  - Else if `OutOfQuantum`=1, latch `CurPC` and go to SAVE.
  - On either trigger, pulse `PREEMP_OFF` in the trigger cycle.
  - The request is ignored while `Halted`=1, except that a rising `ProcValid` restarts scheduling at PICK.
- SAVE: 32 cycles, index k=0..31.
  - `MemWrite`=1 and `MemAddr`=slot(CurPID)+k.
  - Data for k=0 is the latched PC.
  - Data for k≥1 is `RegReadData` with `RegReadAddr`=k.
- PICK: 1 cycle.
  - Next PID is the first set bit of `ProcValid` scanning CurPID+1, CurPID+2, … with wrap, ending at CurPID itself.
  - On a Finalize entry, CurPID is excluded.
  - If no candidate exists: set `Halted`=1, go to IDLE, leave `Stall`=1.
- RESTORE: 33 cycles, step j=0..32.
  - For j≤31: `MemRead`=1 and `MemAddr`=slot(newPID)+j.
  - For j≥1, the returned word j−1 is handled as follows:
    - Word 0 is latched into `NewPC`.
    - Other words are written with `RegWrite`=1, `RegWriteAddr`=j−1, `RegWriteData`=`MemReadData`.
- RESUME: 1 cycle.
  - `CurPID` ← newPID.
  - `LoadPC`=1 and `PREEMP_ON`=1.
  - Go to IDLE.
- Triggers arriving during SAVE through RESUME are dropped. The timer is off, so none are expected.
- Outputs not driven by the active state are held at 0. `NewPC` and `CurPID` hold their values.

## Timing
- Reset values:
  - State is IDLE.
  - `CurPID`=0, `NewPC`=0, `Halted`=0.
  - `Stall`, `MemWrite`, `MemRead`, `RegWrite`, `LoadPC`, `PREEMP_ON` and `PREEMP_OFF` are all 0.
- Reset during any state aborts the switch immediately. A partially written slot is left as is.
- `Stall` is combinational and is high in the trigger cycle T (IDLE with an accepted request). It stays high through RESUME and falls in the cycle after RESUME.
- Quantum switch sequence:
  - T: trigger.
  - T+1..T+32: SAVE.
  - T+33: PICK.
  - T+34..T+66: RESTORE.
  - T+67: RESUME (`LoadPC`, `PREEMP_ON`).
  - `Stall` is low at T+68.
- Finalize switch sequence:
  - T: trigger.
  - T+1: PICK.
  - T+2..T+34: RESTORE.
  - T+35: RESUME.
- With only CurPID valid, a quantum switch re-selects CurPID and restores its own just-saved context (full latency).
- PID wraps from NUM_PROCS−1 to 0.

## Test plan
- Reset, then `ProcValid`=8'b0000_0011, CurPID=0, r5=32'hDEAD_BEEF, `CurPC`=0x100, `OutOfQuantum` pulse at T:
  - mem[0x400]=0x100 and mem[0x405]=0xDEADBEEF.
  - CurPID=1 at T+68.
  - `LoadPC` and `PREEMP_ON` high at T+67.
  - `PREEMP_OFF` high at T.
- Preload slot 1 (mem[0x420]=0x2000, mem[0x427]=7) before the quantum switch:
  - r7=7 after RESTORE.
  - `NewPC`=0x2000.
  - No register write to r0.
- `Finalize` and `OutOfQuantum` together at T, `ProcValid`=8'b1000_0001, CurPID=0:
  - No `MemWrite`.
  - CurPID=7 and RESUME at T+35.
- CurPID=7 with `ProcValid`=8'b1000_0001, quantum switch: wraps to CurPID=0.
- `Finalize` with `ProcValid`=0: `Halted`=1 and `Stall` stays 1.
- Then set `ProcValid`=8'b0000_0100: resumes PID 2.
- `Reset` asserted at T+20 of a switch: all outputs 0 next cycle and state IDLE. A later `OutOfQuantum` runs the full 68-cycle sequence.
